// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter.
// Holds the instruction retiring from the memory stage. It also aligns and
// extends load data and drives the register file write port. A retired
// instruction counter sits alongside the stage.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_raw,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  output logic             wb_reg_write,
  output logic [4:0]       wb_waddr,
  output logic [XLEN-1:0]  wb_wdata,
  output logic             wb_valid,
  output logic             wb_load_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic             r_valid;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [1:0]       r_wb_sel;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_alu_result;
  logic [XLEN-1:0]  r_load_raw;
  logic [XLEN-1:0]  r_pc_plus4;
  logic [CNT_W-1:0] r_instret;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load_data;
  logic             w_load_ok;
  logic             w_write_en;
  logic             w_capture;

  // Stage register: flush inserts a cleared bubble and beats stall, stall holds, otherwise capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_wb_sel     <= '0;
      r_funct3     <= '0;
      r_alu_result <= '0;
      r_load_raw   <= '0;
      r_pc_plus4   <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_wb_sel     <= '0;
      r_funct3     <= '0;
      r_alu_result <= '0;
      r_load_raw   <= '0;
      r_pc_plus4   <= '0;
    end else if (!stall) begin
      r_valid      <= mem_valid;
      r_reg_write  <= mem_reg_write;
      r_rd         <= mem_rd;
      r_wb_sel     <= mem_wb_sel;
      r_funct3     <= mem_funct3;
      r_alu_result <= mem_alu_result;
      r_load_raw   <= mem_load_raw;
      r_pc_plus4   <= mem_pc_plus4;
    end
  end

  // A real instruction retires when it is actually captured into the stage
  assign w_capture = mem_valid & ~stall & ~flush;

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instret <= '0;
    end else if (w_capture) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Byte lane picked by the low address bits. The halfword lane ignores bit 0
  // because misaligned halfwords never reach this stage.
  assign w_byte = r_load_raw[{r_alu_result[1:0], 3'b000} +: 8];
  assign w_half = r_load_raw[{r_alu_result[1], 4'b0000} +: 16];

  // Load formatter: extend the selected lane and flag unsupported funct3 codes
  always_comb begin
    w_load_data = '0;
    w_load_ok   = 1'b1;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      3'b010:  w_load_data = r_load_raw;
      default: w_load_ok   = 1'b0;
    endcase
  end

  // Writeback source select; the reserved encoding writes zero
  always_comb begin
    case (r_wb_sel)
      SEL_ALU:  wb_wdata = r_alu_result;
      SEL_LOAD: wb_wdata = w_load_data;
      SEL_LINK: wb_wdata = r_pc_plus4;
      default:  wb_wdata = '0;
    endcase
  end

  // x0, the reserved select and bad loads never write the register file
  assign w_write_en = r_valid & r_reg_write & (r_rd != 5'd0) & (r_wb_sel != 2'b11)
                    & ~((r_wb_sel == SEL_LOAD) & ~w_load_ok);

  assign wb_reg_write = w_write_en;
  assign wb_waddr     = w_write_en ? r_rd : 5'd0;
  assign wb_valid     = r_valid;
  assign wb_load_err  = r_valid & (r_wb_sel == SEL_LOAD) & ~w_load_ok;
  assign instret      = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, stall/flush and
// reset sequences, then randomized traffic against a behavioural model.
// A second instance with a 3-bit counter exercises counter wrap-around.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset_n;
  logic        stall, flush, mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_raw, mem_pc_plus4;

  logic        wb_reg_write, wb_valid, wb_load_err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [63:0] instret;

  logic        s_reg_write, s_valid, s_load_err;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [2:0]  s_instret;

  mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_raw(mem_load_raw),
    .mem_pc_plus4(mem_pc_plus4),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_valid(wb_valid), .wb_load_err(wb_load_err), .instret(instret)
  );

  mem_wb_stage #(.XLEN(32), .CNT_W(3)) dut_small (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_raw(mem_load_raw),
    .mem_pc_plus4(mem_pc_plus4),
    .wb_reg_write(s_reg_write), .wb_waddr(s_waddr), .wb_wdata(s_wdata),
    .wb_valid(s_valid), .wb_load_err(s_load_err), .instret(s_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: the instruction currently sitting in writeback
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_raw, m_pc;
  logic [63:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
    m_alu = 0; m_raw = 0; m_pc = 0;
  endtask

  // Expected outputs derived arithmetically from the held instruction
  task automatic model_out(output logic we, output logic [4:0] wa,
                           output logic [31:0] wd, output logic err);
    int unsigned off, b, h;
    logic legal;
    off = m_alu % 4;
    b = (m_raw / (32'd1 << (8 * off))) % 256;
    h = (m_raw / (32'd1 << (16 * (off / 2)))) % 65536;
    legal = 1;
    wd = 0;
    if (m_sel == 2'd0) wd = m_alu;
    else if (m_sel == 2'd2) wd = m_pc;
    else if (m_sel == 2'd1) begin
      case (m_f3)
        3'd0: wd = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        3'd4: wd = b;
        3'd1: wd = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        3'd5: wd = h;
        3'd2: wd = m_raw;
        default: legal = 0;
      endcase
    end
    err = m_valid && m_sel == 2'd1 && !legal;
    we  = m_valid && m_rw && m_rd != 0 && m_sel != 2'd3 && !(m_sel == 2'd1 && !legal);
    wa  = we ? m_rd : 5'd0;
  endtask

  task automatic check_all(input string tag);
    logic we, err;
    logic [4:0] wa;
    logic [31:0] wd;
    model_out(we, wa, wd, err);
    chk({tag, ".valid"}, {63'd0, wb_valid}, {63'd0, m_valid});
    chk({tag, ".we"}, {63'd0, wb_reg_write}, {63'd0, we});
    chk({tag, ".waddr"}, {59'd0, wb_waddr}, {59'd0, wa});
    chk({tag, ".wdata"}, {32'd0, wb_wdata}, {32'd0, wd});
    chk({tag, ".lderr"}, {63'd0, wb_load_err}, {63'd0, err});
    chk({tag, ".instret"}, instret, m_cnt);
    chk({tag, ".instret3"}, {61'd0, s_instret}, m_cnt % 8);
  endtask

  // Drive at negedge, let one rising edge capture, update model, check at negedge
  task automatic step(input logic v, input logic rw, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] raw,
                      input logic [31:0] pc, input logic st, input logic fl,
                      input string tag);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_raw = raw; mem_pc_plus4 = pc;
    stall = st; flush = fl;
    @(posedge clk);
    if (fl) model_clear();
    else if (!st) begin
      m_valid = v; m_rw = rw; m_rd = rd; m_sel = sel; m_f3 = f3;
      m_alu = alu; m_raw = raw; m_pc = pc;
    end
    if (v && !st && !fl) m_cnt = m_cnt + 1;
    @(negedge clk);
    check_all(tag);
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] raw;
    logic [31:0] pc;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] r;
    // rd, sel, f3, alu, raw, pc, we, waddr, wdata, err
    vecs[0]  = '{5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'h0,         32'h0,   1, 5'd5, 32'h1234_5678, 0};
    vecs[1]  = '{5'd3, 2'b01, 3'd0, 32'h1000_0001, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'h0000_007F, 0};
    vecs[2]  = '{5'd3, 2'b01, 3'd0, 32'h1000_0002, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'hFFFF_FFFF, 0};
    vecs[3]  = '{5'd3, 2'b01, 3'd4, 32'h1000_0003, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'h0000_0080, 0};
    vecs[4]  = '{5'd3, 2'b01, 3'd1, 32'h1000_0002, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'hFFFF_80FF, 0};
    vecs[5]  = '{5'd3, 2'b01, 3'd5, 32'h1000_0000, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'h0000_7F01, 0};
    vecs[6]  = '{5'd3, 2'b01, 3'd2, 32'h1000_0003, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'h80FF_7F01, 0};
    vecs[7]  = '{5'd3, 2'b01, 3'd0, 32'h1000_0000, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'h0000_0001, 0};
    vecs[8]  = '{5'd3, 2'b01, 3'd0, 32'h1000_0003, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'hFFFF_FF80, 0};
    vecs[9]  = '{5'd3, 2'b01, 3'd5, 32'h1000_0003, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'h0000_80FF, 0};
    vecs[10] = '{5'd3, 2'b01, 3'd1, 32'h1000_0001, 32'h80FF_7F01, 32'h0,   1, 5'd3, 32'h0000_7F01, 0};
    vecs[11] = '{5'd0, 2'b00, 3'd0, 32'h0000_DEAD, 32'h0,         32'h0,   0, 5'd0, 32'h0000_DEAD, 0};
    vecs[12] = '{5'd7, 2'b01, 3'd3, 32'h1000_0000, 32'h80FF_7F01, 32'h0,   0, 5'd0, 32'h0000_0000, 1};
    vecs[13] = '{5'd1, 2'b10, 3'd0, 32'h0000_0040, 32'h0,         32'h104, 1, 5'd1, 32'h0000_0104, 0};
    vecs[14] = '{5'd4, 2'b11, 3'd0, 32'h0000_0055, 32'h0,         32'h0,   0, 5'd0, 32'h0000_0000, 0};
    vecs[15] = '{5'd9, 2'b01, 3'd7, 32'h1000_0002, 32'h1234_5678, 32'h0,   0, 5'd0, 32'h0000_0000, 1};

    reset_n = 0; stall = 0; flush = 0; mem_valid = 0; mem_reg_write = 0;
    mem_rd = 0; mem_wb_sel = 0; mem_funct3 = 0;
    mem_alu_result = 0; mem_load_raw = 0; mem_pc_plus4 = 0;
    model_clear(); m_cnt = 0;

    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1;
    @(negedge clk);
    check_all("idle");

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      step(1, 1, vecs[i].rd, vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].raw,
           vecs[i].pc, 0, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_we", i), {63'd0, wb_reg_write}, {63'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d.tbl_waddr", i), {59'd0, wb_waddr}, {59'd0, vecs[i].exp_waddr});
      chk($sformatf("vec%0d.tbl_wdata", i), {32'd0, wb_wdata}, {32'd0, vecs[i].exp_wdata});
      chk($sformatf("vec%0d.tbl_err", i), {63'd0, wb_load_err}, {63'd0, vecs[i].exp_err});
      $display("[TB] vec %0d: we=%0b waddr=%0d wdata=%h err=%0b instret=%0d",
               i, wb_reg_write, wb_waddr, wb_wdata, wb_load_err, instret);
    end
    chk("vec.instret_total", instret, 64'd16);

    // Stall holds instruction A for three cycles despite changing inputs
    step(1, 1, 5'd9, 2'b00, 3'd0, 32'h0000_00AA, 32'h0, 32'h0, 0, 0, "stallA");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5'(10 + i), 2'b10, 3'd0, 32'h5555_0000 + i, 32'h0, 32'h200, 1, 0,
           $sformatf("stall%0d", i));
      chk($sformatf("stall%0d.hold_wdata", i), {32'd0, wb_wdata}, 64'h0000_00AA);
      chk($sformatf("stall%0d.hold_waddr", i), {59'd0, wb_waddr}, 64'd9);
    end
    chk("stall.instret", instret, 64'd17);
    // Flush beats stall
    step(1, 1, 5'd12, 2'b00, 3'd0, 32'h0000_0BAD, 32'h0, 32'h0, 1, 1, "flush_stall");
    chk("flush_stall.valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_stall.instret", instret, 64'd17);

    // Asynchronous reset between edges while a write is pending
    step(1, 1, 5'd6, 2'b00, 3'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0, "pre_rst");
    chk("pre_rst.we", {63'd0, wb_reg_write}, 64'd1);
    #2;
    reset_n = 0;
    #1;
    model_clear(); m_cnt = 0;
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1;
    check_all("post_rst");

    // Randomized traffic; runs long enough to wrap the 3-bit counter many times
    for (int i = 0; i < 400; i++) begin
      logic [31:0] raw;
      r = $urandom;
      raw = $urandom;
      step(r[0] | r[1], r[2] | r[3], 5'(r[8:4] & {5{r[9] | r[10]}}), r[12:11], r[15:13],
           $urandom, raw, $urandom, (r[17:16] == 2'b00), (r[21:18] == 4'd0),
           $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback formatter for the 5-stage RV32I core.
- Captures the retiring instruction from the memory stage.
- Aligns and sign/zero-extends load data and selects the writeback source.
- Drives the register file write port (reg_write, waddr, wdata).
- Exports writeback-stage info for forwarding and keeps a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold stage contents
flush  in  1  replace incoming instruction with bubble
mem_valid  in  1  memory stage holds a real instruction
mem_reg_write  in  1  instruction writes rd
mem_rd  in  5  destination register
mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
mem_funct3  in  3  load size/sign (RV32I encoding)
mem_alu_result  in  XLEN  ALU result / effective address
mem_load_raw  in  XLEN  raw aligned word from data memory
mem_pc_plus4  in  XLEN  link value
wb_reg_write  out  1  register file write enable
wb_waddr  out  5  register file write address
wb_wdata  out  XLEN  register file write data
wb_valid  out  1  stage holds a valid instruction
wb_load_err  out  1  illegal load funct3 in stage
instret  out  CNT_W  retired-instruction count

Behaviour:
Reset (async, reset_n=0):
- All stage registers clear.
- wb_valid=0, wb_reg_write=0, wb_waddr=0, wb_wdata=0, wb_load_err=0, instret=0.
- Reset mid-operation discards the held instruction immediately, with no write.

Capture at each rising edge, in priority order:
- flush=1: valid_q<=0. Other fields are don't-care but are cleared to 0. flush beats stall.
- else stall=1: all stage registers hold.
- else: load all mem_* fields. valid_q<=mem_valid.

Latency:
- Instruction presented at edge N drives writeback outputs from after edge N until the next capture.
- Register file write occurs at edge N+1.

Outputs (combinational from stage registers only; no combinational path from mem_* inputs):
- wb_valid = valid_q.
- wb_reg_write = valid_q & reg_write_q & (rd_q != 0) & (wb_sel_q != 11).
- wb_waddr = rd_q when wb_reg_write, else 0.
- wb_wdata:
  - wb_sel 00: alu_result_q.
  - wb_sel 10: pc_plus4_q.
  - wb_sel 01: load formatter (below).
  - wb_sel 11: 0.

Load formatter (off = alu_result_q[1:0]):
- funct3 000 LB: byte [8*off+7:8*off], sign-extended.
- funct3 100 LBU: same byte, zero-extended.
- funct3 001 LH: halfword at [16*off[1]+15:16*off[1]], sign-extended. off[0] ignored; misalignment is trapped upstream.
- funct3 101 LHU: same halfword, zero-extended.
- funct3 010 LW: full word. off ignored.
- funct3 011/110/111: wdata=0, write suppressed, wb_load_err = valid_q & (wb_sel_q==01).

Stall while holding a write:
- wb_reg_write stays asserted, so the same value is rewritten each cycle. This is idempotent and acceptable.

instret:
- Increments by 1 at a rising edge when a valid instruction is captured: mem_valid & !stall & !flush.
- Bubbles, stalled cycles and flushed instructions do not count.
- Wraps modulo 2^CNT_W without saturation.

x0: rd=0 never asserts wb_reg_write, but the instruction still counts in instret.

Test Plan:
- Reset then ALU op: mem_valid=1, reg_write=1, rd=5, wb_sel=00, alu_result=0x1234_5678 -> next cycle wb_reg_write=1, wb_waddr=5, wb_wdata=0x1234_5678, instret=1.
- Load formatting: load_raw=0x80FF_7F01 with alu_result[1:0]=0,1,2,3 and LB/LBU/LH/LHU/LW ->
  - LB off1=0xFFFF_FF7F? No: byte1=0x7F, so LB off1=0x0000_007F; LB off2=0xFFFF_FFFF; LBU off3=0x0000_0080.
  - LH off2=0xFFFF_80FF; LHU off0=0x0000_7F01; LW=0x80FF_7F01.
- Write suppression: rd=0 ALU op -> wb_reg_write=0, instret increments. funct3=011 load to rd=7 -> wb_reg_write=0, wb_load_err=1, wdata=0.
- Stall/flush: valid instr A captured, then stall=1 for 3 cycles with different mem_* inputs -> outputs hold A, instret +1 total. Then stall=1 and flush=1 together -> wb_valid=0 next cycle, instret unchanged.
- JAL link: wb_sel=10, pc_plus4=0x0000_0104, rd=1 -> wb_wdata=0x0000_0104, wb_waddr=1.
- Async reset mid-write: assert reset_n=0 between clock edges while wb_reg_write=1 -> all outputs 0 immediately, without waiting for an edge. Also preload instret=2^64-1 via force, capture one valid instr -> instret=0.
